// File: rtl/param_sync_updown_cntr_pkg.sv
// Shared counter definitions: direction encoding used by every up/down counter in the tree.
package param_sync_updown_cntr_pkg;
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;
endpackage

// File: rtl/param_sync_updown_cntr_t_ff.sv
// Single T flip-flop: q toggles on a rising clk edge when t is high, async active-low clear.
module param_sync_updown_cntr_t_ff (
  input  logic clk,
  input  logic rstn,
  input  logic t,
  output logic q
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)  q <= 1'b0;
    else if (t) q <= ~q;
  end
endmodule

// File: rtl/param_sync_updown_cntr.sv
// Modulo-MODULUS up/down counter built from T flip-flops; carry/borrow output for cascading.
module param_sync_updown_cntr
  import param_sync_updown_cntr_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cnt_en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic [WIDTH-1:0] T_in
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_V = (WIDTH+1)'(MODULUS);

  generate
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
      $error("param_sync_updown_cntr: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
  endgenerate

  logic             at_max, at_zero;
  logic [WIDTH-1:0] count_next;

  assign at_max  = (count == MAX_V);
  assign at_zero = (count == '0);

  // Carry is a pure terminal-count decode; clr/load do not mask it.
  assign carry = cnt_en & ((up_dn == CNT_UP) ? at_max : at_zero);

  always_comb begin
    count_next = count;
    if (clr)
      count_next = '0;
    else if (load)
      count_next = ({1'b0, load_val} < MOD_V) ? load_val : MAX_V;
    else if (cnt_en) begin
      if (up_dn == CNT_UP) count_next = at_max  ? '0    : count + WIDTH'(1);
      else                 count_next = at_zero ? MAX_V : count - WIDTH'(1);
    end
  end

  // The state lives in the T flip-flops, so the toggle vector is the next-state function.
  assign T_in = count ^ count_next;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      param_sync_updown_cntr_t_ff u_tff (
        .clk  (clk),
        .rstn (rstn),
        .t    (T_in[i]),
        .q    (count[i])
      );
    end
  endgenerate
endmodule

// File: tb/tb_param_sync_updown_cntr.sv
// Bench: a modulo-16 counter and a two-digit BCD cascade checked against an arithmetic model.
module tb_param_sync_updown_cntr;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic       en16 = 0, up16 = 0, clr16 = 0, ld16 = 0;
  logic [3:0] lv16 = 0, count16, t16;
  logic       carry16;

  logic       en_c = 0, up_c = 0, clr_c = 0, ld_c = 0;
  logic [3:0] lvlo = 0, lvhi = 0, count_lo, count_hi, t_lo, t_hi;
  logic       carry_lo, carry_hi;

  param_sync_updown_cntr #(.WIDTH(4), .MODULUS(16)) u16 (
    .clk(clk), .rstn(rstn), .cnt_en(en16), .up_dn(up16), .clr(clr16), .load(ld16),
    .load_val(lv16), .count(count16), .carry(carry16), .T_in(t16));

  param_sync_updown_cntr #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .rstn(rstn), .cnt_en(en_c), .up_dn(up_c), .clr(clr_c), .load(ld_c),
    .load_val(lvlo), .count(count_lo), .carry(carry_lo), .T_in(t_lo));

  param_sync_updown_cntr #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .rstn(rstn), .cnt_en(carry_lo), .up_dn(up_c), .clr(clr_c), .load(ld_c),
    .load_val(lvhi), .count(count_hi), .carry(carry_hi), .T_in(t_hi));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
  endtask

  // Reference rules in plain modular arithmetic.
  function automatic int nxt(int c, bit en, bit up, bit cl, bit ld, int lv, int m);
    if (cl) return 0;
    if (ld) return (lv < m) ? lv : m - 1;
    if (en) return up ? (c + 1) % m : (c + m - 1) % m;
    return c;
  endfunction

  function automatic bit cry(int c, bit en, bit up, int m);
    return en && (up ? (c == m - 1) : (c == 0));
  endfunction

  int m16 = 0, mlo = 0, mhi = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m16 <= 0; mlo <= 0; mhi <= 0;
    end else begin
      m16 <= nxt(m16, en16, up16, clr16, ld16, int'(lv16), 16);
      mlo <= nxt(mlo, en_c, up_c, clr_c, ld_c, int'(lvlo), 10);
      mhi <= nxt(mhi, cry(mlo, en_c, up_c, 10), up_c, clr_c, ld_c, int'(lvhi), 10);
    end
  end

  always @(negedge clk) begin
    bit en_hi;
    en_hi = cry(mlo, en_c, up_c, 10);
    chk("u16_count", 32'(count16), 32'(m16));
    chk("u16_carry", 32'(carry16), 32'(cry(m16, en16, up16, 16)));
    chk("u16_t_in",  32'(t16), 32'(m16 ^ nxt(m16, en16, up16, clr16, ld16, int'(lv16), 16)));
    chk("lo_count",  32'(count_lo), 32'(mlo));
    chk("lo_carry",  32'(carry_lo), 32'(en_hi));
    chk("lo_t_in",   32'(t_lo), 32'(mlo ^ nxt(mlo, en_c, up_c, clr_c, ld_c, int'(lvlo), 10)));
    chk("hi_count",  32'(count_hi), 32'(mhi));
    chk("hi_carry",  32'(carry_hi), 32'(cry(mhi, en_hi, up_c, 10)));
    chk("hi_t_in",   32'(t_hi), 32'(mhi ^ nxt(mhi, en_hi, up_c, clr_c, ld_c, int'(lvhi), 10)));
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  initial begin
    #1 rstn = 0;
    repeat (2) tick();
    chk("reset_count16", 32'(count16), 0);
    rstn = 1;

    // Free-running up count on both the mod-16 counter and the BCD low digit.
    en16 = 1; up16 = 1; en_c = 1; up_c = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("up16_seq", 32'(count16), 32'(i));
      if (i == 9) begin
        #1 chk("lo_carry_at_9", 32'(carry_lo), 1);
        chk("lo_at_9", 32'(count_lo), 9);
      end
      if (i == 10) begin
        chk("lo_wrap_0", 32'(count_lo), 0);
        chk("hi_after_wrap", 32'(count_hi), 1);
      end
    end
    #1 chk("u16_carry_at_15", 32'(carry16), 1);
    tick();
    chk("u16_wrap_0", 32'(count16), 0);

    // Down from 00 borrows through both digits.
    clr_c = 1; tick(); clr_c = 0;
    up_c = 0; en_c = 1;
    #1 chk("lo_borrow_at_0", 32'(carry_lo), 1);
    tick();
    chk("lo_down_wrap", 32'(count_lo), 9);
    chk("hi_down_wrap", 32'(count_hi), 9);

    // Load priority, clamp and clr-over-load.
    ld_c = 1; lvlo = 7; lvhi = 3; tick();
    chk("load_7", 32'(count_lo), 7);
    chk("load_hi_3", 32'(count_hi), 3);
    lvlo = 12; tick();
    chk("load_clamp", 32'(count_lo), 9);
    clr_c = 1; tick();
    chk("clr_over_load", 32'(count_lo), 0);
    clr_c = 0; ld_c = 0; en_c = 0;

    // Toggle vector across the 0111 -> 1000 transition, then hold.
    en16 = 0; ld16 = 1; lv16 = 7; tick();
    chk("load16_7", 32'(count16), 7);
    ld16 = 0; en16 = 1; up16 = 1;
    #1 chk("t_in_0111", 32'(t16), 32'hf);
    tick();
    chk("count_1000", 32'(count16), 8);
    en16 = 0;
    #1 chk("t_in_hold", 32'(t16), 0);
    chk("carry_hold", 32'(carry16), 0);
    tick();
    chk("count_held", 32'(count16), 8);

    // Asynchronous reset between edges.
    ld16 = 1; lv16 = 5; tick(); ld16 = 0;
    chk("load16_5", 32'(count16), 5);
    rstn = 0;
    #1 chk("async_reset", 32'(count16), 0);
    #1 rstn = 1; en16 = 1;
    tick();
    chk("resume_from_0", 32'(count16), 1);

    // Full BCD cascade 00..99 and wrap in both directions.
    en16 = 0; clr_c = 1; tick(); clr_c = 0;
    en_c = 1; up_c = 1;
    repeat (99) tick();
    chk("bcd_99_lo", 32'(count_lo), 9);
    chk("bcd_99_hi", 32'(count_hi), 9);
    #1 chk("bcd_99_carry", 32'(carry_hi), 1);
    tick();
    chk("bcd_00_lo", 32'(count_lo), 0);
    chk("bcd_00_hi", 32'(count_hi), 0);
    up_c = 0; tick();
    chk("bcd_dn_lo", 32'(count_lo), 9);
    chk("bcd_dn_hi", 32'(count_hi), 9);

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rstn  = ($urandom_range(0, 199) != 0);
      en16  = ($urandom_range(0, 3) != 0);
      up16  = 1'($urandom);
      clr16 = ($urandom_range(0, 15) == 0);
      ld16  = ($urandom_range(0, 15) == 0);
      lv16  = 4'($urandom);
      en_c  = ($urandom_range(0, 3) != 0);
      up_c  = ($urandom_range(0, 63) < 40) ? up_c : ~up_c;
      clr_c = ($urandom_range(0, 31) == 0);
      ld_c  = ($urandom_range(0, 31) == 0);
      lvlo  = 4'($urandom);
      lvhi  = 4'($urandom);
    end
    rstn = 1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
